// File: rtl/rr_req_gnt_arbiter.sv
// rr_req_gnt_arbiter: N-channel round-robin req/gnt arbiter with grant latency, bounded hold and sticky starvation flags.
// Optional: define ARB_SVA_EN to compile in concurrent assertions; ports and behaviour are otherwise identical.
module rr_req_gnt_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int GNT_LAT   = 1,
  parameter int MAX_HOLD  = 8,
  parameter int TO_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      err_clr,
  output logic [NUM_CH-1:0]         gnt,
  output logic                      gnt_vld,
  output logic [$clog2(NUM_CH)-1:0] gnt_id,
  output logic [NUM_CH-1:0]         timeout
);
  localparam int IW = $clog2(NUM_CH);
  localparam int LW = $clog2(GNT_LAT + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int PW = $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

  state_t            state_q;
  logic [IW-1:0]     ptr_q, own_q, win, idx, own_nxt;
  logic [LW-1:0]     lat_q;
  logic [HW-1:0]     hold_q;
  logic [NUM_CH-1:0] gnt_q, to_q, to_set, to_d;
  logic [PW-1:0]     pend_q [NUM_CH];
  logic [PW-1:0]     pend_d [NUM_CH];
  logic              release_own;

  // Round-robin pick: scan downward so the lowest offset from ptr wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % NUM_CH);
      if (req[idx]) win = idx;
    end
  end

  assign own_nxt     = (own_q == IW'(NUM_CH - 1)) ? '0 : own_q + 1'b1;
  assign release_own = !req[own_q] || (hold_q == HW'(MAX_HOLD) && |(req & ~gnt_q));

  // Arbitration FSM; gnt is a register so it drops asynchronously on reset.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      lat_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else
      case (state_q)
        IDLE:
          if (|req) begin
            own_q <= win;
            if (GNT_LAT == 1) begin
              state_q <= GRANT;
              gnt_q   <= NUM_CH'(1) << win;
              hold_q  <= HW'(1);
            end else begin
              state_q <= WAIT;
              lat_q   <= LW'(GNT_LAT - 1);
            end
          end
        WAIT:
          if (!req[own_q]) state_q <= IDLE;
          else if (lat_q == LW'(1)) begin
            state_q <= GRANT;
            gnt_q   <= NUM_CH'(1) << own_q;
            hold_q  <= HW'(1);
          end else lat_q <= lat_q - 1'b1;
        GRANT:
          if (release_own) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            hold_q  <= '0;
            ptr_q   <= own_nxt;
          end else if (hold_q != HW'(MAX_HOLD)) hold_q <= hold_q + 1'b1;
        default: state_q <= IDLE;
      endcase

  // Per-channel pending counters; the flag sets only on the edge the count first reaches the limit.
  always_comb
    for (int i = 0; i < NUM_CH; i++) begin
      pend_d[i] = (req[i] && !gnt_q[i]) ? ((pend_q[i] == PW'(TO_CYCLES)) ? pend_q[i] : pend_q[i] + 1'b1) : '0;
      to_set[i] = req[i] && !gnt_q[i] && pend_q[i] == PW'(TO_CYCLES - 1);
    end

  assign to_d = (to_q & ~{NUM_CH{err_clr}}) | to_set;

  // Starvation state; a new set beats err_clr on the same edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pend_q <= '{default: '0};
      to_q   <= '0;
    end else begin
      pend_q <= pend_d;
      to_q   <= to_d;
    end

  assign gnt     = gnt_q;
  assign gnt_vld = |gnt_q;
  assign gnt_id  = gnt_vld ? own_q : '0;
  assign timeout = to_q;

`ifdef ARB_SVA_EN
  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt))
    else $error("gnt not one-hot-or-zero: %b", gnt);
  a_gap: assert property (@(posedge clk) disable iff (reset) $fell(gnt_vld) && $past(state_q) == GRANT |=> !gnt_vld)
    else $error("ch %0d: grant resumed without idle gap", gnt_id);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_sva
    a_req: assert property (@(posedge clk) disable iff (reset) gnt[i] |-> $past(req[i]))
      else $error("ch %0d: granted without request", i);
    a_starve: assert property (@(posedge clk) disable iff (reset) req[i] && !gnt[i] |-> ##[1:TO_CYCLES] (gnt[i] || !req[i]))
      else $error("ch %0d: starved beyond TO_CYCLES", i);
  end
`endif
endmodule
